// File: rtl/udp_perf_pkg.sv
// Shared types and pattern helper for the UDP/CMAC loop performance tester.
package udp_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } gen_state_t;

  localparam int unsigned PAT_WORD_W = 32;

  // One 32-bit pattern word: packet sequence in the upper half, beat index in the lower.
  function automatic logic [PAT_WORD_W-1:0] pat_word(input logic [15:0] seq, input logic [15:0] beat);
    return {seq, beat};
  endfunction

endpackage

// File: rtl/udp_perf_checker.sv
// Loopback checker: compares the RX stream against the expected pattern,
// resynchronises on every tlast and keeps the RX-side statistics.
// Optional: PERF_LATENCY_EN masks the first-beat timestamp and tracks round-trip latency.
module udp_perf_checker #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [15:0]           beats,
  input  logic                  rx_beat,
  input  logic                  rx_last,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [CNT_WIDTH-1:0]  now,
  output logic [CNT_WIDTH-1:0]  rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  rx_beat_cnt,
  output logic [CNT_WIDTH-1:0]  rx_cycle_cnt,
  output logic                  rx_cycle_full,
  output logic [CNT_WIDTH-1:0]  lat_min,
  output logic [CNT_WIDTH-1:0]  lat_max
);
  import udp_perf_pkg::*;

  logic [15:0]           exp_seq;
  logic [15:0]           exp_beat;
  logic                  pkt_bad;
  logic                  beat_bad;
  logic                  rx_started;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] cmp_mask;
  logic [CNT_WIDTH-1:0]  live_cyc;
  logic [CNT_WIDTH-1:0]  live_next;
  logic                  live_ovf;
  logic                  live_ovf_next;

  // Expected beat and per-beat error decision (data mismatch or tlast on the wrong beat).
  always_comb begin
    exp_data = '0;
    cmp_mask = '1;
    for (int unsigned i = 0; i < DATA_WIDTH / PAT_WORD_W; i++)
      exp_data[i*PAT_WORD_W +: PAT_WORD_W] = pat_word(exp_seq, exp_beat);
`ifdef PERF_LATENCY_EN
    if (exp_beat == '0) cmp_mask[63:32] = '0;
`endif
    beat_bad = (((rx_data ^ exp_data) & cmp_mask) != '0) ||
               (rx_last != (exp_beat == beats - 16'd1));
  end

  // Running cycle count since the first RX beat; committed to rx_cycle_cnt at each tlast.
  always_comb begin
    live_next     = CNT_WIDTH'(1);
    live_ovf_next = live_ovf;
    if (rx_started) begin
      if (live_cyc == '1) begin
        live_next     = live_cyc;
        live_ovf_next = 1'b1;
      end else begin
        live_next = live_cyc + CNT_WIDTH'(1);
      end
    end
  end

  // RX tracking state and saturating statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_seq       <= '0;
      exp_beat      <= '0;
      pkt_bad       <= 1'b0;
      rx_started    <= 1'b0;
      live_cyc      <= '0;
      live_ovf      <= 1'b0;
      rx_pkt_cnt    <= '0;
      err_pkt_cnt   <= '0;
      rx_beat_cnt   <= '0;
      rx_cycle_cnt  <= '0;
      rx_cycle_full <= 1'b0;
    end else if (clear) begin
      exp_seq       <= '0;
      exp_beat      <= '0;
      pkt_bad       <= 1'b0;
      rx_started    <= 1'b0;
      live_cyc      <= '0;
      live_ovf      <= 1'b0;
      rx_pkt_cnt    <= '0;
      err_pkt_cnt   <= '0;
      rx_beat_cnt   <= '0;
      rx_cycle_cnt  <= '0;
      rx_cycle_full <= 1'b0;
    end else begin
      if (rx_started || rx_beat) begin
        rx_started <= 1'b1;
        live_cyc   <= live_next;
        live_ovf   <= live_ovf_next;
      end
      if (rx_beat) begin
        if (rx_beat_cnt != '1) rx_beat_cnt <= rx_beat_cnt + CNT_WIDTH'(1);
        if (rx_last) begin
          if (rx_pkt_cnt != '1) rx_pkt_cnt <= rx_pkt_cnt + CNT_WIDTH'(1);
          if ((pkt_bad || beat_bad) && (err_pkt_cnt != '1))
            err_pkt_cnt <= err_pkt_cnt + CNT_WIDTH'(1);
          // Resync to the received sequence so a single drop costs a single error.
          exp_seq      <= rx_data[31:16] + 16'd1;
          exp_beat     <= '0;
          pkt_bad      <= 1'b0;
          rx_cycle_cnt <= live_next;
          if (live_ovf_next) rx_cycle_full <= 1'b1;
        end else begin
          exp_beat <= exp_beat + 16'd1;
          pkt_bad  <= pkt_bad || beat_bad;
        end
      end
    end
  end

`ifdef PERF_LATENCY_EN
  logic [CNT_WIDTH-1:0] lat_now;
  assign lat_now = CNT_WIDTH'(32'(now) - rx_data[63:32]);

  // Min/max round-trip latency measured on every first beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_min <= '0;
      lat_max <= '0;
    end else if (clear) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (rx_beat && (exp_beat == '0)) begin
      if (lat_now < lat_min) lat_min <= lat_now;
      if (lat_now > lat_max) lat_max <= lat_now;
    end
  end
`else
  logic unused_now;
  assign unused_now = ^now;
  assign lat_min    = '0;
  assign lat_max    = '0;
`endif

endmodule

// File: rtl/udp_loop_perf_tester.sv
// AXI-Stream pattern generator with loopback checker and performance counters
// for UDP/CMAC loop tests. Optional build macro: PERF_LATENCY_EN (timestamp in
// first-beat bits [63:32] and round-trip latency tracking).
module udp_loop_perf_tester #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [15:0]           cfg_pkt_beats,
  input  logic [15:0]           cfg_pkt_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_pkt_num,
  output logic                  tx_axis_tvalid,
  input  logic                  tx_axis_tready,
  output logic                  tx_axis_tlast,
  output logic [DATA_WIDTH-1:0] tx_axis_tdata,
  output logic [KEEP_WIDTH-1:0] tx_axis_tkeep,
  output logic                  tx_axis_tuser,
  input  logic                  rx_axis_tvalid,
  output logic                  rx_axis_tready,
  input  logic                  rx_axis_tlast,
  input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic                  rx_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  rx_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  tx_beat_cnt,
  output logic [CNT_WIDTH-1:0]  rx_beat_cnt,
  output logic [CNT_WIDTH-1:0]  tx_cycle_cnt,
  output logic [CNT_WIDTH-1:0]  rx_cycle_cnt,
  output logic                  tx_cycle_full,
  output logic                  rx_cycle_full,
  output logic [CNT_WIDTH-1:0]  lat_min,
  output logic [CNT_WIDTH-1:0]  lat_max
);
  import udp_perf_pkg::*;

  gen_state_t           state;
  logic [15:0]          beats_q;
  logic [15:0]          gap_q;
  logic [15:0]          gap_cnt;
  logic [15:0]          pkt_seq;
  logic [15:0]          beat_idx;
  logic [CNT_WIDTH-1:0] num_q;
  logic                 stop_pend;
  logic                 tx_started;
  logic                 tx_hs;
  logic                 last_beat;
  logic                 start_ok;
  logic                 count_done;
  logic                 unused_rx;

  assign tx_hs      = tx_axis_tvalid && tx_axis_tready;
  assign last_beat  = (beat_idx == beats_q - 16'd1);
  assign start_ok   = cfg_start && (state == IDLE);
  assign count_done = (num_q != '0) && (tx_pkt_cnt + CNT_WIDTH'(1) == num_q);
  assign unused_rx  = ^{rx_axis_tkeep, rx_axis_tuser};

  assign busy           = (state != IDLE);
  assign tx_axis_tvalid = (state == SEND);
  assign tx_axis_tlast  = (state == SEND) && last_beat;
  assign tx_axis_tkeep  = (state == SEND) ? '1 : '0;
  assign tx_axis_tuser  = 1'b0;

`ifdef PERF_LATENCY_EN
  logic [CNT_WIDTH-1:0] ts;
  logic [CNT_WIDTH-1:0] ts_hold;

  // Free-running timestamp; the copy on the wire freezes while a first beat waits for tready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts      <= '0;
      ts_hold <= '0;
    end else begin
      ts <= ts + CNT_WIDTH'(1);
      if (!(tx_axis_tvalid && (beat_idx == '0) && !tx_axis_tready)) ts_hold <= ts;
    end
  end
`endif

  // TX beat contents: replicated pattern word, zero when not sending.
  always_comb begin
    tx_axis_tdata = '0;
    if (state == SEND) begin
      for (int unsigned i = 0; i < DATA_WIDTH / PAT_WORD_W; i++)
        tx_axis_tdata[i*PAT_WORD_W +: PAT_WORD_W] = pat_word(pkt_seq, beat_idx);
`ifdef PERF_LATENCY_EN
      if (beat_idx == '0) tx_axis_tdata[63:32] = 32'(ts_hold);
`endif
    end
  end

  // Generator FSM: beat/packet sequencing, inter-packet gap, stop and count termination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beats_q   <= 16'd1;
      gap_q     <= '0;
      num_q     <= '0;
      gap_cnt   <= '0;
      pkt_seq   <= '0;
      beat_idx  <= '0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            beats_q   <= (cfg_pkt_beats == '0) ? 16'd1 : cfg_pkt_beats;
            gap_q     <= cfg_pkt_gap;
            num_q     <= cfg_pkt_num;
            pkt_seq   <= '0;
            beat_idx  <= '0;
            stop_pend <= 1'b0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (cfg_stop) stop_pend <= 1'b1;
          if (tx_hs) begin
            if (last_beat) begin
              beat_idx <= '0;
              pkt_seq  <= pkt_seq + 16'd1;
              if (stop_pend || cfg_stop || count_done) begin
                state <= DONE;
              end else if (gap_q != '0) begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end
            end else begin
              beat_idx <= beat_idx + 16'd1;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          if (cfg_stop || stop_pend) state <= DONE;
          else if (gap_cnt == 16'd1) state <= SEND;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // TX statistics; the cycle counter runs from the first handshake until DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pkt_cnt    <= '0;
      tx_beat_cnt   <= '0;
      tx_cycle_cnt  <= '0;
      tx_cycle_full <= 1'b0;
      tx_started    <= 1'b0;
    end else if (start_ok) begin
      tx_pkt_cnt    <= '0;
      tx_beat_cnt   <= '0;
      tx_cycle_cnt  <= '0;
      tx_cycle_full <= 1'b0;
      tx_started    <= 1'b0;
    end else begin
      if (tx_hs && (tx_beat_cnt != '1)) tx_beat_cnt <= tx_beat_cnt + CNT_WIDTH'(1);
      if (tx_hs && last_beat && (tx_pkt_cnt != '1)) tx_pkt_cnt <= tx_pkt_cnt + CNT_WIDTH'(1);
      if (((state == SEND) || (state == GAP)) && (tx_started || tx_hs)) begin
        tx_started <= 1'b1;
        if (tx_cycle_cnt == '1) tx_cycle_full <= 1'b1;
        else                    tx_cycle_cnt  <= tx_cycle_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // RX side is always ready once out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_axis_tready <= 1'b0;
    else       rx_axis_tready <= 1'b1;
  end

  udp_perf_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_checker (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_ok),
    .beats         (beats_q),
    .rx_beat       (rx_axis_tvalid && rx_axis_tready),
    .rx_last       (rx_axis_tlast),
    .rx_data       (rx_axis_tdata),
`ifdef PERF_LATENCY_EN
    .now           (ts),
`else
    .now           ('0),
`endif
    .rx_pkt_cnt    (rx_pkt_cnt),
    .err_pkt_cnt   (err_pkt_cnt),
    .rx_beat_cnt   (rx_beat_cnt),
    .rx_cycle_cnt  (rx_cycle_cnt),
    .rx_cycle_full (rx_cycle_full),
    .lat_min       (lat_min),
    .lat_max       (lat_max)
  );

endmodule

// File: tb/tb_udp_loop_perf_tester.sv
// Directed bench for udp_loop_perf_tester: a 512-bit/32-bit-counter instance
// looped back through a fault-injecting path, plus a 64-bit/8-bit-counter
// instance for counter saturation and asynchronous reset.
module tb_udp_loop_perf_tester;

  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int CW  = 32;
  localparam int DWB = 64;
  localparam int KWB = DWB / 8;
  localparam int CWB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic          a_start = 1'b0, a_stop = 1'b0;
  logic [15:0]   a_beats = 16'd4, a_gap = 16'd0;
  logic [CW-1:0] a_num = '0;
  logic          a_tx_valid, a_tx_ready = 1'b1, a_tx_last, a_tx_user;
  logic [DW-1:0] a_tx_data;
  logic [KW-1:0] a_tx_keep;
  logic          a_rx_valid, a_rx_ready, a_rx_last, a_rx_user;
  logic [DW-1:0] a_rx_data;
  logic [KW-1:0] a_rx_keep;
  logic          a_busy, a_tx_full, a_rx_full;
  logic [CW-1:0] a_tx_pkt, a_rx_pkt, a_err, a_tx_beat, a_rx_beat, a_tx_cyc, a_rx_cyc, a_lat_min, a_lat_max;

  // Instance B signals
  logic           b_start = 1'b0;
  logic           b_stop = 1'b0;
  logic [15:0]    b_beats = 16'd4, b_gap = 16'd0;
  logic [CWB-1:0] b_num = '0;
  logic           b_tx_valid, b_tx_last, b_tx_user;
  logic           b_tx_ready = 1'b1;
  logic [DWB-1:0] b_tx_data;
  logic [KWB-1:0] b_tx_keep;
  logic           b_rx_valid, b_rx_ready, b_rx_last, b_rx_user;
  logic [DWB-1:0] b_rx_data;
  logic [KWB-1:0] b_rx_keep;
  logic           b_busy, b_tx_full, b_rx_full;
  logic [CWB-1:0] b_tx_pkt, b_rx_pkt, b_err, b_tx_beat, b_rx_beat, b_tx_cyc, b_rx_cyc, b_lat_min, b_lat_max;

  // Loopback fault controls
  logic toggle_en = 1'b0;
  logic drop_en = 1'b0, flip_en = 1'b0, tl_en = 1'b0;
  int   drop_pkt = 0, flip_pkt = 0, flip_beat = 0, tl_pkt = 0;

  // Bench-side beat/packet position of the beat currently on the TX bus
  int mon_pkt = 0, mon_beat = 0;
  int viol = 0;
  logic          pend = 1'b0, pend_last = 1'b0;
  logic [DW-1:0] pend_data = '0;

  int n_checks = 0, n_pass = 0;

  udp_loop_perf_tester #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset(reset), .cfg_start(a_start), .cfg_stop(a_stop),
    .cfg_pkt_beats(a_beats), .cfg_pkt_gap(a_gap), .cfg_pkt_num(a_num),
    .tx_axis_tvalid(a_tx_valid), .tx_axis_tready(a_tx_ready), .tx_axis_tlast(a_tx_last),
    .tx_axis_tdata(a_tx_data), .tx_axis_tkeep(a_tx_keep), .tx_axis_tuser(a_tx_user),
    .rx_axis_tvalid(a_rx_valid), .rx_axis_tready(a_rx_ready), .rx_axis_tlast(a_rx_last),
    .rx_axis_tdata(a_rx_data), .rx_axis_tkeep(a_rx_keep), .rx_axis_tuser(a_rx_user),
    .busy(a_busy), .tx_pkt_cnt(a_tx_pkt), .rx_pkt_cnt(a_rx_pkt), .err_pkt_cnt(a_err),
    .tx_beat_cnt(a_tx_beat), .rx_beat_cnt(a_rx_beat), .tx_cycle_cnt(a_tx_cyc), .rx_cycle_cnt(a_rx_cyc),
    .tx_cycle_full(a_tx_full), .rx_cycle_full(a_rx_full), .lat_min(a_lat_min), .lat_max(a_lat_max)
  );

  udp_loop_perf_tester #(.DATA_WIDTH(DWB), .KEEP_WIDTH(KWB), .CNT_WIDTH(CWB)) dut_b (
    .clk(clk), .reset(reset), .cfg_start(b_start), .cfg_stop(b_stop),
    .cfg_pkt_beats(b_beats), .cfg_pkt_gap(b_gap), .cfg_pkt_num(b_num),
    .tx_axis_tvalid(b_tx_valid), .tx_axis_tready(b_tx_ready), .tx_axis_tlast(b_tx_last),
    .tx_axis_tdata(b_tx_data), .tx_axis_tkeep(b_tx_keep), .tx_axis_tuser(b_tx_user),
    .rx_axis_tvalid(b_rx_valid), .rx_axis_tready(b_rx_ready), .rx_axis_tlast(b_rx_last),
    .rx_axis_tdata(b_rx_data), .rx_axis_tkeep(b_rx_keep), .rx_axis_tuser(b_rx_user),
    .busy(b_busy), .tx_pkt_cnt(b_tx_pkt), .rx_pkt_cnt(b_rx_pkt), .err_pkt_cnt(b_err),
    .tx_beat_cnt(b_tx_beat), .rx_beat_cnt(b_rx_beat), .tx_cycle_cnt(b_tx_cyc), .rx_cycle_cnt(b_rx_cyc),
    .tx_cycle_full(b_tx_full), .rx_cycle_full(b_rx_full), .lat_min(b_lat_min), .lat_max(b_lat_max)
  );

  // Loopback A with optional drop, bit flip and forced tlast
  always_comb begin
    a_rx_valid = a_tx_valid && a_tx_ready && !(drop_en && (mon_pkt == drop_pkt));
    a_rx_last  = a_tx_last || (tl_en && (mon_pkt == tl_pkt) && (mon_beat == 0));
    a_rx_data  = a_tx_data;
    if (flip_en && (mon_pkt == flip_pkt) && (mon_beat == flip_beat))
      a_rx_data[100] = ~a_tx_data[100];
    a_rx_keep  = a_tx_keep;
    a_rx_user  = a_tx_user;
  end

  // Plain loopback B
  always_comb begin
    b_rx_valid = b_tx_valid && b_tx_ready;
    b_rx_last  = b_tx_last;
    b_rx_data  = b_tx_data;
    b_rx_keep  = b_tx_keep;
    b_rx_user  = b_tx_user;
  end

  // tready: constant 1 or toggling every cycle
  always @(negedge clk) a_tx_ready = toggle_en ? ~a_tx_ready : 1'b1;

  // Position tracker and AXIS hold-rule watcher
  always @(posedge clk) begin
    if (a_start) begin
      mon_pkt  <= 0;
      mon_beat <= 0;
    end else if (a_tx_valid && a_tx_ready) begin
      if (mon_beat == int'(a_beats) - 1) begin
        mon_beat <= 0;
        mon_pkt  <= mon_pkt + 1;
      end else begin
        mon_beat <= mon_beat + 1;
      end
    end
    if (pend && (!a_tx_valid || (a_tx_data != pend_data) || (a_tx_last != pend_last)))
      viol <= viol + 1;
    pend      <= a_tx_valid && !a_tx_ready;
    pend_data <= a_tx_data;
    pend_last <= a_tx_last;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_a(input int beats, input int gap, input int num);
    @(negedge clk);
    a_beats = 16'(beats);
    a_gap   = 16'(gap);
    a_num   = CW'(num);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_idle_a(input int max_cyc);
    int n = 0;
    while (a_busy && (n < max_cyc)) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", 64'(a_busy), 64'd0);
  endtask

  task automatic clear_faults();
    drop_en = 1'b0;
    flip_en = 1'b0;
    tl_en   = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_tvalid", 64'(a_tx_valid), 64'd0);
    check_eq("rst_busy", 64'(a_busy), 64'd0);
    check_eq("rst_rx_tready", 64'(a_rx_ready), 64'd0);
    check_eq("rst_tx_pkt", 64'(a_tx_pkt), 64'd0);
    check_eq("rst_tkeep", 64'(a_tx_keep), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rx_tready_after_rst", 64'(a_rx_ready), 64'd1);

    // 1: 10 x 4 beats back-to-back
    start_a(4, 0, 10);
    for (int i = 0; (i < 200) && !((mon_pkt == 2) && (mon_beat == 1)); i++) @(negedge clk);
    check_eq("pat_p2b1_lo", 64'(a_tx_data[31:0]), 64'h0002_0001);
    check_eq("pat_p2b1_hi", 64'(a_tx_data[DW-1 -: 32]), 64'h0002_0001);
    check_eq("pat_p2b1_keep", 64'(&a_tx_keep), 64'd1);
    check_eq("pat_p2b1_last", 64'(a_tx_last), 64'd0);
    wait_idle_a(200);
    check_eq("t1_tx_pkt", 64'(a_tx_pkt), 64'd10);
    check_eq("t1_rx_pkt", 64'(a_rx_pkt), 64'd10);
    check_eq("t1_tx_beat", 64'(a_tx_beat), 64'd40);
    check_eq("t1_rx_beat", 64'(a_rx_beat), 64'd40);
    check_eq("t1_err", 64'(a_err), 64'd0);
    check_eq("t1_tx_cyc", 64'(a_tx_cyc), 64'd40);
    check_eq("t1_rx_cyc", 64'(a_rx_cyc), 64'd40);
    check_eq("t1_tx_full", 64'(a_tx_full), 64'd0);
`ifndef PERF_LATENCY_EN
    check_eq("t1_lat_min", 64'(a_lat_min), 64'd0);
    check_eq("t1_lat_max", 64'(a_lat_max), 64'd0);
`endif

    // 2: gap 3, tready toggling
    toggle_en = 1'b1;
    start_a(2, 3, 5);
    wait_idle_a(300);
    toggle_en = 1'b0;
    check_eq("t2_hold_viol", 64'(viol), 64'd0);
    check_eq("t2_tx_pkt", 64'(a_tx_pkt), 64'd5);
    check_eq("t2_rx_pkt", 64'(a_rx_pkt), 64'd5);
    check_eq("t2_tx_beat", 64'(a_tx_beat), 64'd10);
    check_eq("t2_err", 64'(a_err), 64'd0);

    // 3: packet 3 of 8 dropped
    clear_faults();
    drop_en = 1'b1; drop_pkt = 3;
    start_a(4, 1, 8);
    wait_idle_a(300);
    check_eq("t3_tx_pkt", 64'(a_tx_pkt), 64'd8);
    check_eq("t3_rx_pkt", 64'(a_rx_pkt), 64'd7);
    check_eq("t3_err", 64'(a_err), 64'd1);
    check_eq("t3_rx_beat", 64'(a_rx_beat), 64'd28);

    // 4: one bit flipped in packet 2 beat 1
    clear_faults();
    flip_en = 1'b1; flip_pkt = 2; flip_beat = 1;
    start_a(4, 0, 4);
    wait_idle_a(200);
    check_eq("t4_rx_pkt", 64'(a_rx_pkt), 64'd4);
    check_eq("t4_err", 64'(a_err), 64'd1);

    // 5: tlast forced on beat 0 of packet 1: it splits into two RX packets, both bad
    clear_faults();
    tl_en = 1'b1; tl_pkt = 1;
    start_a(4, 0, 4);
    wait_idle_a(200);
    clear_faults();
    check_eq("t5_rx_pkt", 64'(a_rx_pkt), 64'd5);
    check_eq("t5_err", 64'(a_err), 64'd2);

    // 6: unlimited run, stop at packet 1 beat 1
    start_a(4, 0, 0);
    for (int i = 0; (i < 100) && !((mon_pkt == 1) && (mon_beat == 1)); i++) @(negedge clk);
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    for (int i = 0; (i < 20) && !(a_tx_valid && a_tx_last); i++) @(negedge clk);
    check_eq("t6_tlast", 64'(a_tx_valid && a_tx_last), 64'd1);
    check_eq("t6_last_beat", 64'(mon_beat), 64'd3);
    @(negedge clk);
    check_eq("t6_busy_done", 64'(a_busy), 64'd1);
    check_eq("t6_tvalid_done", 64'(a_tx_valid), 64'd0);
    @(negedge clk);
    check_eq("t6_busy_idle", 64'(a_busy), 64'd0);
    check_eq("t6_tx_pkt", 64'(a_tx_pkt), 64'd2);
    check_eq("t6_tx_beat", 64'(a_tx_beat), 64'd8);
    check_eq("t6_err", 64'(a_err), 64'd0);

    // 7: 8-bit counters saturate on an unlimited run
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("t7_busy", 64'(b_busy), 64'd1);
    check_eq("t7_tx_cyc", 64'(b_tx_cyc), 64'd255);
    check_eq("t7_tx_full", 64'(b_tx_full), 64'd1);
    check_eq("t7_tx_beat", 64'(b_tx_beat), 64'd255);
    check_eq("t7_rx_cyc", 64'(b_rx_cyc), 64'd255);
    check_eq("t7_rx_full", 64'(b_rx_full), 64'd1);
    check_eq("t7_err", 64'(b_err), 64'd0);

    // 8: asynchronous reset in the middle of SEND
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t8_tvalid", 64'(b_tx_valid), 64'd0);
    check_eq("t8_busy", 64'(b_busy), 64'd0);
    check_eq("t8_tdata", 64'(b_tx_data), 64'd0);
    check_eq("t8_tx_cyc", 64'(b_tx_cyc), 64'd0);
    check_eq("t8_tx_full", 64'(b_tx_full), 64'd0);
    check_eq("t8_rx_pkt", 64'(b_rx_pkt), 64'd0);
    check_eq("t8_rx_tready", 64'(b_rx_ready), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
